// File: rtl/veda_mem_arbiter.sv
// Round-robin two-master arbiter that sequences accesses to the 32-word Veda scratch memory.
// Memory pins are registered from the next state, so they are aligned with the WRITE/READ cycles.
module veda_mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address_a,
   output logic [ADDR_W-1:0] mem_address_b,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write_enable,
   output logic              mem_mode,
   input  logic [DATA_W-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RDCAP = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_LSB = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                id_q, id_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_id_q, rsp_id_d;
   logic                rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                busy_q, busy_d;
   logic                we_q, we_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
   logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic                grant_s;
   logic                hs_s;

   // A tie goes to the master not granted last; a lone requester always wins.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_q;
      end else begin
         grant_s = ~req0_valid;
      end
   end

   assign req0_ready = (state_q == IDLE) && !reset && req0_valid && !grant_s;
   assign req1_ready = (state_q == IDLE) && !reset && req1_valid && grant_s;
   assign hs_s       = req0_ready || req1_ready;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         IDLE: begin
            if (hs_s) begin
               id_d    = grant_s;
               last_d  = grant_s;
               write_d = grant_s ? req1_write : req0_write;
               addr_d  = grant_s ? req1_addr  : req0_addr;
               wdata_d = grant_s ? req1_wdata : req0_wdata;
               state_d = (grant_s ? req1_write : req0_write) ? WRITE : READ;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_rdata_d = {DATA_W{1'b0}};
            state_d     = IDLE;
         end
         READ: begin
            state_d = RDCAP;
         end
         RDCAP: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = 1'b0;
            rsp_id_d    = id_q;
            rsp_rdata_d = mem_data_out;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Address pair always differs by the LSB while accessing, so the lockout never fires.
   always_comb begin
      busy_d   = (state_d != IDLE);
      we_d     = 1'b0;
      mode_d   = 1'b0;
      addr_a_d = {ADDR_W{1'b0}};
      addr_b_d = {ADDR_W{1'b0}};
      din_d    = {DATA_W{1'b0}};
      case (state_d)
         WRITE: begin
            we_d     = 1'b1;
            addr_a_d = addr_d;
            addr_b_d = addr_d ^ ADDR_LSB;
            din_d    = wdata_d;
         end
         READ: begin
            mode_d   = 1'b1;
            addr_b_d = addr_d;
            addr_a_d = addr_d ^ ADDR_LSB;
         end
         default: begin
            we_d   = 1'b0;
            mode_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         id_q        <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
         we_q        <= 1'b0;
         mode_q      <= 1'b0;
         addr_a_q    <= {ADDR_W{1'b0}};
         addr_b_q    <= {ADDR_W{1'b0}};
         din_q       <= {DATA_W{1'b0}};
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
         we_q        <= we_d;
         mode_q      <= mode_d;
         addr_a_q    <= addr_a_d;
         addr_b_q    <= addr_b_d;
         din_q       <= din_d;
      end
   end

   assign rsp_valid        = rsp_valid_q;
   assign rsp_id           = rsp_id_q;
   assign rsp_write        = rsp_write_q;
   assign rsp_rdata        = rsp_rdata_q;
   assign busy             = busy_q;
   assign mem_write_enable = we_q;
   assign mem_mode         = mode_q;
   assign mem_address_a    = addr_a_q;
   assign mem_address_b    = addr_b_q;
   assign mem_data_in      = din_q;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Bench for veda_mem_arbiter: a scratch-memory stand-in, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_veda_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req0_write;
   logic [4:0]  req0_addr;
   logic [31:0] req0_wdata;
   logic        req1_valid, req1_ready, req1_write;
   logic [4:0]  req1_addr;
   logic [31:0] req1_wdata;
   logic        rsp_valid, rsp_id, rsp_write;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic [4:0]  mem_address_a, mem_address_b;
   logic [31:0] mem_data_in, mem_data_out;
   logic        mem_write_enable, mem_mode;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int pulses = 0;

   veda_mem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .busy(busy),
      .mem_address_a(mem_address_a), .mem_address_b(mem_address_b),
      .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
      .mem_mode(mem_mode), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rsp_valid === 1'b1) pulses <= pulses + 1;

   // Scratch memory: write on port A in mode 0, registered read on port B in mode 1, no-op on equal addresses.
   logic [31:0] ram [32];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) ram[i] <= 32'd0;
         mem_data_out <= 32'd0;
      end else if (mem_address_a != mem_address_b) begin
         if (mem_write_enable && !mem_mode) ram[mem_address_a] <= mem_data_in;
         if (mem_mode) mem_data_out <= ram[mem_address_b];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: the latest accepted request decides every output for the cycles that follow it.
   int          c = 0;
   bit          armed = 1'b0;
   bit          h_vld = 1'b0;
   int          h_cyc;
   bit          h_wr, h_id;
   logic [4:0]  h_addr;
   logic [31:0] h_data;
   bit          ptr = 1'b1;
   logic [31:0] ref_mem [32];
   bit          l_id = 1'b0, l_wr = 1'b0;
   logic [31:0] l_rd = 32'd0;

   always @(negedge clk) begin : model
      bit e_busy, e_we, e_mode, e_rv, g, e_r0, e_r1;
      logic [4:0]  e_a, e_b;
      logic [31:0] e_din;
      int d;
      e_busy = 1'b0; e_we = 1'b0; e_mode = 1'b0; e_rv = 1'b0;
      e_a = 5'd0; e_b = 5'd0; e_din = 32'd0;
      if (h_vld) begin
         d = c - h_cyc;
         if (d == 0) begin
            e_busy = 1'b1;
            if (h_wr) begin
               e_we = 1'b1; e_a = h_addr; e_b = h_addr ^ 5'd1; e_din = h_data;
            end else begin
               e_mode = 1'b1; e_b = h_addr; e_a = h_addr ^ 5'd1;
            end
         end
         if (d == 1 && !h_wr) e_busy = 1'b1;
         if (d == (h_wr ? 1 : 2)) begin
            e_rv = 1'b1; l_id = h_id; l_wr = h_wr; l_rd = h_wr ? 32'd0 : h_data;
         end
      end
      g = (req0_valid && req1_valid) ? ~ptr : !req0_valid;
      e_r0 = !reset && !e_busy && req0_valid && !g;
      e_r1 = !reset && !e_busy && req1_valid && g;
      if (armed) begin
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv});
         chk("rsp_id", {31'd0, rsp_id}, {31'd0, l_id});
         chk("rsp_write", {31'd0, rsp_write}, {31'd0, l_wr});
         chk("rsp_rdata", rsp_rdata, l_rd);
         chk("busy", {31'd0, busy}, {31'd0, e_busy});
         chk("mem_we", {31'd0, mem_write_enable}, {31'd0, e_we});
         chk("mem_mode", {31'd0, mem_mode}, {31'd0, e_mode});
         chk("mem_addr_a", {27'd0, mem_address_a}, {27'd0, e_a});
         chk("mem_addr_b", {27'd0, mem_address_b}, {27'd0, e_b});
         chk("mem_data_in", mem_data_in, e_din);
         if (e_we || e_mode) chk("addr_a_ne_b", {31'd0, mem_address_a != mem_address_b}, 32'd1);
         chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
         chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
      end
      if (reset) begin
         armed = 1'b1; h_vld = 1'b0; ptr = 1'b1;
         l_id = 1'b0; l_wr = 1'b0; l_rd = 32'd0;
         for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
      end else if (e_r0 || e_r1) begin
         h_vld = 1'b1; h_cyc = c + 1; h_id = g; ptr = g;
         h_wr   = g ? req1_write : req0_write;
         h_addr = g ? req1_addr : req0_addr;
         h_data = g ? req1_wdata : req0_wdata;
         if (h_wr) ref_mem[h_addr] = h_data;
         else h_data = ref_mem[h_addr];
      end
      c++;
   end

   // One request from master m, then wait for its response; lat counts cycles from handshake.
   task automatic do_req(input bit m, input bit wr, input logic [4:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
      bit got;
      int hs;
      @(posedge clk); #1;
      if (m) begin
         req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = wd;
      end else begin
         req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = wd;
      end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if ((m ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
         @(posedge clk);
      end
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      hs = cyc;
      rd = 32'hXXXX_XXXX; lat = -1;
      if (!got) chk("handshake_timeout", 32'd0, 32'd1);
      else begin
         for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
               lat = cyc - hs; rd = rsp_rdata;
               chk("rsp_id_lit", {31'd0, rsp_id}, {31'd0, m});
               chk("rsp_write_lit", {31'd0, rsp_write}, {31'd0, wr});
            end
         end
         if (lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] rd;
      int lat, grants[6], hsc[4], p0;
      bit found;
      logic [4:0] raddr[4];
      raddr[0] = 5'd5; raddr[1] = 5'd0; raddr[2] = 5'd31; raddr[3] = 5'd10;

      reset = 1'b1;
      req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 5'd10; req0_wdata = 32'hA0A0_A0A0;
      req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 5'd11; req1_wdata = 32'hB1B1_B1B1;
      @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Both masters keep writing; grants must alternate starting with master 0.
      for (int k = 0; k < 6; k++) begin
         found = 1'b0;
         grants[k] = -1;
         for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
               found = 1'b1; grants[k] = (req1_ready === 1'b1) ? 1 : 0;
            end
         end
         @(posedge clk);
      end
      #1; req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 0; k < 6; k++) chk("fair_grant", grants[k], k % 2);
      repeat (3) @(posedge clk);

      do_req(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, rd, lat);
      chk("wr_ack_lat", lat, 32'd1);
      chk("wr_ack_data", rd, 32'd0);
      do_req(1'b0, 1'b0, 5'd5, 32'd0, rd, lat);
      chk("rd_lat", lat, 32'd2);
      chk("rd5_data", rd, 32'hDEAD_BEEF);

      do_req(1'b0, 1'b1, 5'd0, 32'h1234_5678, rd, lat);
      do_req(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, rd, lat);
      do_req(1'b0, 1'b0, 5'd0, 32'd0, rd, lat);
      chk("rd0_data", rd, 32'h1234_5678);
      do_req(1'b1, 1'b0, 5'd31, 32'd0, rd, lat);
      chk("rd31_data", rd, 32'hFFFF_FFFF);
      do_req(1'b0, 1'b0, 5'd1, 32'd0, rd, lat);
      chk("rd1_untouched", rd, 32'd0);
      do_req(1'b1, 1'b0, 5'd30, 32'd0, rd, lat);
      chk("rd30_untouched", rd, 32'd0);
      do_req(1'b0, 1'b0, 5'd11, 32'd0, rd, lat);
      chk("rd11_fair_data", rd, 32'hB1B1_B1B1);

      // Master 1 alone: four back-to-back reads, 3 cycles apart.
      @(posedge clk); #1;
      p0 = pulses;
      req1_valid = 1'b1; req1_write = 1'b0; req1_addr = raddr[0];
      for (int k = 0; k < 4; k++) begin
         found = 1'b0; hsc[k] = -100;
         for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (req1_ready === 1'b1) begin found = 1'b1; hsc[k] = cyc; end
         end
         @(posedge clk); #1;
         if (k < 3) req1_addr = raddr[k+1];
         else req1_valid = 1'b0;
      end
      for (int k = 1; k < 4; k++) chk("single_spacing", hsc[k] - hsc[k-1], 32'd3);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("single_pulses", pulses - p0, 32'd4);

      // Reset during RDCAP: the in-flight read never responds and memory is cleared.
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 5'd5;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (req0_ready === 1'b1) found = 1'b1;
         @(posedge clk);
      end
      if (!found) chk("midrst_handshake", 32'd0, 32'd1);
      #1; req0_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      p0 = pulses;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_rsp", {31'd0, rsp_valid}, 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_no_pulse", pulses - p0, 32'd0);
      do_req(1'b0, 1'b0, 5'd5, 32'd0, rd, lat);
      chk("cleared5", rd, 32'd0);
      do_req(1'b1, 1'b0, 5'd31, 32'd0, rd, lat);
      chk("cleared31", rd, 32'd0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
